// File: rtl/wb_commit.sv
// Write-back commit buffer: queues EX results in a DEPTH-entry FIFO and retires them into a 32x32 register file.
// Latency: a result pushed at edge N commits at edge N+1 at the earliest; read ports and hazard flag are combinational.
// Backpressure: ex_ready drops while the FIFO is full (no pass-through on a full drain cycle); wb_stall holds the head.
module wb_commit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    output logic        ex_ready,
    input  logic        wb_stall,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    output logic        raw_pending,
    output logic [31:0] last_commit,
    output logic [31:0] commit_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } wb_entry_t;

    wb_entry_t       ent_q [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     rf [32];

    logic            push;
    logic            drain;
    wb_entry_t       head;
    logic [AW-1:0]   offs [DEPTH];
    logic [DEPTH-1:0] ent_live;

    assign ex_ready = (count < CW'(DEPTH));
    assign push     = ex_valid & ex_ready;
    assign drain    = (count != '0) & ~wb_stall;
    assign head     = ent_q[rd_ptr];

    // An entry still counts as pending unless it is the head leaving this cycle.
    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        assign offs[g]     = AW'(g) - rd_ptr;
        assign ent_live[g] = ({1'b0, offs[g]} < count) && !(drain && (AW'(g) == rd_ptr));
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_q[wr_ptr] <= '{rd: ex_rd, result: ex_result};
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Register file write port; r0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (drain && (head.rd != 5'd0)) begin
            rf[head.rd] <= head.result;
        end
    end

    // Commit statistics; rd=0 drains still count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count <= '0;
            last_commit  <= '0;
        end else if (drain) begin
            commit_count <= commit_count + 32'd1;
            last_commit  <= head.result;
        end
    end

    // Read ports forward the head result when it is being written this cycle.
    always_comb begin
        ra_data = rf[ra_addr];
        rb_data = rf[rb_addr];
        if (drain && (head.rd != 5'd0) && (head.rd == ra_addr)) begin
            ra_data = head.result;
        end
        if (drain && (head.rd != 5'd0) && (head.rd == rb_addr)) begin
            rb_data = head.result;
        end
    end

    // Hazard: some buffered nonzero-destination entry not yet visible through the read ports.
    always_comb begin
        raw_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live[i] && (ent_q[i].rd != 5'd0) &&
                ((ent_q[i].rd == ra_addr) || (ent_q[i].rd == rb_addr))) begin
                raw_pending = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: vector table for per-cycle read/hazard outputs,
// scoreboard queue for commit order, hand sequences for reset and steady push/drain.
module tb_wb_commit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_ready;
    logic        wb_stall;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        raw_pending;
    logic [31:0] last_commit;
    logic [31:0] commit_count;

    wb_commit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .ex_ready     (ex_ready),
        .wb_stall     (wb_stall),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .ra_data      (ra_data),
        .rb_data      (rb_data),
        .raw_pending  (raw_pending),
        .last_commit  (last_commit),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        st;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_rdy;
        logic        e_raw;
        logic [31:0] e_ra;
        logic [31:0] e_rb;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } ent_t;

    vec_t  tbl [$];
    ent_t  exp_q [$];
    int    m_cnt;
    int    m_commits;
    logic [31:0] m_last;
    int    n_chk;
    int    n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] rd, input logic [31:0] res, input logic st,
                       input logic [4:0] ra, input logic [4:0] rb, input logic e_rdy, input logic e_raw,
                       input logic [31:0] e_ra, input logic [31:0] e_rb);
        vec_t t;
        t.v = v; t.rd = rd; t.res = res; t.st = st; t.ra = ra; t.rb = rb;
        t.e_rdy = e_rdy; t.e_raw = e_raw; t.e_ra = e_ra; t.e_rb = e_rb;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res, input logic st,
                         input logic [4:0] a, input logic [4:0] b);
        ex_valid  = v;
        ex_rd     = rd;
        ex_result = res;
        wb_stall  = st;
        ra_addr   = a;
        rb_addr   = b;
        #1;
    endtask

    // Advance one cycle: predict push/drain, update scoreboard, check commit outputs.
    task automatic tick();
        bit   m_push;
        bit   m_drain;
        ent_t e;
        chk("ready_model", {31'd0, ex_ready}, {31'd0, (m_cnt < DEPTH)});
        m_push  = ex_valid && (m_cnt < DEPTH);
        m_drain = (m_cnt > 0) && !wb_stall;
        if (m_push) begin
            e.rd  = ex_rd;
            e.res = ex_result;
        end
        @(posedge clk);
        if (m_drain) begin
            ent_t h;
            h = exp_q.pop_front();
            m_commits++;
            m_last = h.res;
            m_cnt--;
        end
        if (m_push) begin
            exp_q.push_back(e);
            m_cnt++;
        end
        #1;
        chk("commit_count", commit_count, 32'(m_commits));
        chk("last_commit", last_commit, m_last);
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        m_cnt = 0; m_commits = 0; m_last = 0;
        reset = 1'b1;
        ex_valid = 0; ex_rd = 0; ex_result = 0; wb_stall = 0; ra_addr = 3; rb_addr = 0;

        // Fibonacci stream into r3
        add(1,3,1,0, 3,0, 1,0, 0,0);
        add(1,3,2,0, 3,0, 1,0, 1,0);
        add(1,3,3,0, 3,0, 1,0, 2,0);
        add(1,3,5,0, 3,0, 1,0, 3,0);
        add(1,3,8,0, 3,0, 1,0, 5,0);
        add(0,0,0,0, 3,0, 1,0, 8,0);
        add(0,0,0,0, 3,3, 1,0, 8,8);
        // Full buffer under stall, fifth push ignored, then drain in order
        add(1,4,100,1, 4,0, 1,0, 0,0);
        add(1,5,101,1, 4,0, 1,1, 0,0);
        add(1,6,102,1, 4,0, 1,1, 0,0);
        add(1,7,103,1, 4,0, 1,1, 0,0);
        add(1,8,104,1, 4,0, 0,1, 0,0);
        add(0,0,0,0,   4,0, 0,0, 100,0);
        add(0,0,0,0,   5,0, 1,0, 101,0);
        add(0,0,0,0,   8,0, 1,0, 0,0);
        add(0,0,0,0,   7,0, 1,0, 103,0);
        add(0,0,0,0,   6,4, 1,0, 102,100);
        // Bypass / hazard on r3
        add(1,3,13,1, 3,0, 1,0, 8,0);
        add(0,0,0,1,  0,3, 1,1, 0,8);
        add(0,0,0,0,  3,3, 1,0, 13,13);
        add(0,0,0,0,  3,0, 1,0, 13,0);
        // Zero register
        add(1,0,21,0, 0,0, 1,0, 0,0);
        add(0,0,0,0,  0,0, 1,0, 0,0);
        add(0,0,0,0,  0,3, 1,0, 0,13);

        #3;
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_count", commit_count, 32'd0);
        chk("rst_last", last_commit, 32'd0);
        chk("rst_r3", ra_data, 32'd0);
        chk("rst_raw", {31'd0, raw_pending}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rd, tbl[i].res, tbl[i].st, tbl[i].ra, tbl[i].rb);
            chk($sformatf("v%0d_ready", i), {31'd0, ex_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_raw", i), {31'd0, raw_pending}, {31'd0, tbl[i].e_raw});
            chk($sformatf("v%0d_ra", i), ra_data, tbl[i].e_ra);
            chk($sformatf("v%0d_rb", i), rb_data, tbl[i].e_rb);
            tick();
        end
        chk("tbl_commits", commit_count, 32'd11);
        chk("tbl_last", last_commit, 32'd21);

        // Reset mid-operation with three buffered entries
        drive(1,9,900,1, 0,0);  tick();
        drive(1,10,901,1, 0,0); tick();
        drive(1,11,902,1, 0,0); tick();
        drive(0,0,0,1, 9,10);
        chk("pre_rst_raw", {31'd0, raw_pending}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("mid_rst_count", commit_count, 32'd0);
        chk("mid_rst_last", last_commit, 32'd0);
        chk("mid_rst_raw", {31'd0, raw_pending}, 32'd0);
        exp_q.delete();
        m_cnt = 0; m_commits = 0; m_last = 0;
        drive(0,0,0,0, 3,4);
        chk("mid_rst_r3", ra_data, 32'd0);
        chk("mid_rst_r4", rb_data, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_count", commit_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First push right after reset, then nothing left over from before reset
        drive(1,1,55,0, 1,0);  tick();
        drive(0,0,0,0, 1,9);
        chk("post_rst_bypass", ra_data, 32'd55);
        chk("post_rst_r9", rb_data, 32'd0);
        tick();
        drive(0,0,0,0, 10,11); tick();
        chk("post_rst_r10", ra_data, 32'd0);
        chk("post_rst_r11", rb_data, 32'd0);
        chk("post_rst_commits", commit_count, 32'd1);

        // Steady push+drain at occupancy 2 for 10 cycles
        drive(1,20,1020,1, 0,0); tick();
        drive(1,21,1021,1, 0,0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(22 + i), 32'(1022 + i), 0, 5'(21 + i), 0);
            chk($sformatf("ss%0d_ready", i), {31'd0, ex_ready}, 32'd1);
            chk($sformatf("ss%0d_raw", i), {31'd0, raw_pending}, 32'd1);
            tick();
        end
        drive(0,0,0,0, 0,0); tick();
        drive(0,0,0,0, 0,0); tick();
        drive(0,0,0,0, 20,31);
        chk("ss_r20", ra_data, 32'd1020);
        chk("ss_r31", rb_data, 32'd1031);
        chk("ss_raw_idle", {31'd0, raw_pending}, 32'd0);
        tick();
        chk("ss_commits", commit_count, 32'd13);
        chk("ss_last", last_commit, 32'd1031);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
